// File: rtl/frame_sync_fifo.sv
//============================================================================
// frame_sync_fifo
//----------------------------------------------------------------------------
// Single-clock FIFO between the SDRAM read controller and the frame/pixel
// pipeline. It buffers wide SDRAM read beats and gives the controller:
//   * usedw    - registered occupancy, 0..DEPTH
//   * burst_ok - registered credit: a full BURST_LEN read burst will fit
//   * wr_full / rd_empty - registered status flags
// It also keeps sticky overflow/underflow flags for debug.
//
// Storage is an inferred simple dual-port RAM with a registered read port.
// The write port is unregistered and the read data is registered, which
// suits an M10K block.
//
// Build option (macro FRAME_FIFO_SHOWAHEAD_EN):
//   undefined - normal mode. A word popped at edge N is on rd_data, with a
//               one-cycle rd_valid pulse, after edge N. rd_data holds until
//               the next pop.
//   defined   - show-ahead mode. rd_data presents the head word whenever
//               rd_empty is low, and rd_en pops that word. The registered
//               RAM output acts as a prefetch register, so a word written
//               into an empty FIFO at edge N is visible after edge N+1.
//               rd_valid equals !rd_empty, and usedw includes the
//               prefetched word.
//
// Parameters:
//   DATA_W    - data width in bits
//   ADDR_W    - log2(depth); DEPTH = 2**ADDR_W
//   BURST_LEN - beats per SDRAM read burst, 1..DEPTH
//
// Ports:
//   clk           in   sole clock
//   rst           in   synchronous, active-high reset
//   wr_en         in   write request (SDRAM readdatavalid)
//   wr_data       in   write data
//   wr_full       out  usedw == DEPTH
//   burst_ok      out  (DEPTH - usedw) >= BURST_LEN
//   rd_en         in   read request / pop
//   rd_data       out  read data
//   rd_valid      out  rd_data holds a popped word (see build option)
//   rd_empty      out  no word available to read
//   usedw         out  words stored, 0..DEPTH
//   overflow_err  out  sticky: write attempted while full with no read
//   underflow_err out  sticky: read attempted while empty
//   clr_err       in   clears both sticky flags (a same-cycle new error wins)
//============================================================================
module frame_sync_fifo #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              burst_ok,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic [ADDR_W:0]   usedw,
    output logic              overflow_err,
    output logic              underflow_err,
    input  logic              clr_err
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] BURST_C   = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0] USEDW_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_q;       // registered RAM read port

    // ------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------
    logic            rd_accept;    // a word leaves the FIFO this cycle
    logic            wr_accept;    // a word enters the FIFO this cycle
    logic            ram_rd;       // RAM read port fires this cycle
    logic            ovf_set;
    logic            unf_set;
    logic [ADDR_W:0] usedw_next;
    logic [ADDR_W:0] free_next;

    // A read frees a slot in the same cycle, so a full FIFO can still take a
    // write when it is being popped at that edge.
    assign rd_accept = rd_en && !rd_empty;
    assign wr_accept = wr_en && (!wr_full || rd_accept);

    assign ovf_set = wr_en && !wr_accept;
    assign unf_set = rd_en && rd_empty;

    // NOTE: combinational blocks use blocking '=' and assign a default
    // before any branch, so no path leaves a variable unassigned and no
    // latch is inferred.
    always_comb begin
        usedw_next = usedw;
        if (wr_accept && !rd_accept) begin
            usedw_next = usedw + USEDW_ONE;
        end else if (rd_accept && !wr_accept) begin
            usedw_next = usedw - USEDW_ONE;
        end
    end

    // usedw_next never exceeds DEPTH, so this subtraction cannot wrap.
    assign free_next = DEPTH_C - usedw_next;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset. Resetting it would stop it mapping
    // onto a block RAM, and its contents are never observed before being
    // written because the pointers and counters are reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The read register is cleared by reset so rd_data starts at zero.
    // When the FIFO is full and read and written together, wr_ptr equals
    // rd_ptr. The read then returns the old word, because the RAM array is
    // updated with a non-blocking assignment.
    // NOTE: sequential state uses non-blocking '<=' so that every register
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (ram_rd) begin
            rd_q <= mem[rd_ptr];
        end
    end

    assign rd_data = rd_q;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Status is decoded from the next occupancy and registered, so every
    // flag reflects the accesses accepted at the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            usedw    <= '0;
            wr_full  <= 1'b0;
            burst_ok <= 1'b1;
        end else begin
            usedw    <= usedw_next;
            wr_full  <= (usedw_next == DEPTH_C);
            burst_ok <= (free_next >= BURST_C);
        end
    end

`ifdef FRAME_FIFO_SHOWAHEAD_EN
    // ------------------------------------------------------------------
    // Show-ahead: rd_q is a prefetch register holding the head word, and
    // rd_empty marks it as not loaded. usedw counts the head word too, so
    // the RAM still holds at least one unread word exactly when usedw is
    // greater than the head occupancy.
    // ------------------------------------------------------------------
    logic ram_avail;

    assign ram_avail = (usedw != {{ADDR_W{1'b0}}, ~rd_empty});

    // Refill the head when it is empty or being popped this cycle.
    assign ram_rd = ram_avail && (rd_empty || rd_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_empty <= 1'b1;
        end else if (ram_rd) begin
            rd_empty <= 1'b0;
        end else if (rd_accept) begin
            rd_empty <= 1'b1;
        end
    end

    assign rd_valid = !rd_empty;
`else
    // ------------------------------------------------------------------
    // Normal mode: each accepted pop reads the RAM, and the word lands on
    // rd_data after the same edge with a single-cycle rd_valid pulse.
    // ------------------------------------------------------------------
    assign ram_rd = rd_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_empty <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            rd_empty <= (usedw_next == '0);
            rd_valid <= rd_accept;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky error flags. A new error in the clearing cycle wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= ovf_set || (overflow_err  && !clr_err);
            underflow_err <= unf_set || (underflow_err && !clr_err);
        end
    end

endmodule

// File: tb/tb_frame_sync_fifo.sv
`timescale 1ns/1ps
//============================================================================
// tb_frame_sync_fifo
//----------------------------------------------------------------------------
// Directed self-checking bench for frame_sync_fifo. Expected values are
// derived from the data patterns written (index-based words). The bench
// follows FRAME_FIFO_SHOWAHEAD_EN so that the same scenarios run in both
// read modes.
//============================================================================
module tb_frame_sync_fifo;

    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 8;
    localparam int BURST_LEN = 8;
    localparam int DEPTH     = 256;

    typedef logic [DATA_W-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              burst_ok;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic [ADDR_W:0]   usedw;
    logic              overflow_err;
    logic              underflow_err;
    logic              clr_err;

    int total = 0;
    int bad   = 0;

    frame_sync_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .burst_ok     (burst_ok),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_empty     (rd_empty),
        .usedw        (usedw),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input word_t d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    // Pop one word and compare it with exp, in whichever read mode is built.
    task automatic pop_check(input word_t exp, input string tag);
`ifdef FRAME_FIFO_SHOWAHEAD_EN
        for (int k = 0; k < 4 && rd_empty; k++) step();
        check({tag, "_head"}, word_t'(rd_empty), word_t'(0));
        check({tag, "_data"}, rd_data, exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check({tag, "_valid"}, word_t'(rd_valid), word_t'(1));
        check({tag, "_data"}, rd_data, exp);
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_usedw"},    word_t'(usedw),         word_t'(0));
        check({tag, "_empty"},    word_t'(rd_empty),      word_t'(1));
        check({tag, "_full"},     word_t'(wr_full),       word_t'(0));
        check({tag, "_burst_ok"}, word_t'(burst_ok),      word_t'(1));
        check({tag, "_rd_valid"}, word_t'(rd_valid),      word_t'(0));
        check({tag, "_rd_data"},  rd_data,                word_t'(0));
        check({tag, "_ovf"},      word_t'(overflow_err),  word_t'(0));
        check({tag, "_unf"},      word_t'(underflow_err), word_t'(0));
    endtask

    // Watchdog: the directed sequence needs well under 10k cycles.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        clr_err = 1'b0;

        // ---------------- Reset state ----------------
        step();
        check_reset("reset");
        rst = 1'b0;

        // ---------------- Fill from reset ----------------
        for (int i = 0; i < DEPTH; i++) begin
            do_write(word_t'(i));
            check($sformatf("fill_usedw_%0d", i), word_t'(usedw), word_t'(i + 1));
            check($sformatf("fill_burst_%0d", i), word_t'(burst_ok),
                  word_t'((DEPTH - (i + 1)) >= BURST_LEN));
            check($sformatf("fill_full_%0d", i), word_t'(wr_full), word_t'(i == DEPTH - 1));
`ifdef FRAME_FIFO_SHOWAHEAD_EN
            if (i == 0) check("fill_sa_empty_n", word_t'(rd_empty), word_t'(1));
            if (i == 1) begin
                check("fill_sa_empty_n1", word_t'(rd_empty), word_t'(0));
                check("fill_sa_head", rd_data, word_t'(0));
            end
`else
            if (i == 0) check("fill_empty_n", word_t'(rd_empty), word_t'(0));
`endif
        end
        check("fill_ovf", word_t'(overflow_err),  word_t'(0));
        check("fill_unf", word_t'(underflow_err), word_t'(0));

        // ---------------- Overflow ----------------
        wr_en = 1'b1; wr_data = word_t'(16'hDEAD);
        step();
        wr_en = 1'b0;
        check("ovf_usedw", word_t'(usedw),        word_t'(256));
        check("ovf_flag",  word_t'(overflow_err), word_t'(1));
        check("ovf_full",  word_t'(wr_full),      word_t'(1));

        // A clear in the same cycle as a new overflow: the set wins.
        wr_en = 1'b1; wr_data = word_t'(16'hBEEF); clr_err = 1'b1;
        step();
        wr_en = 1'b0;
        check("ovf_setwins", word_t'(overflow_err), word_t'(1));
        check("ovf_setwins_usedw", word_t'(usedw), word_t'(256));
        step();
        clr_err = 1'b0;
        check("ovf_cleared", word_t'(overflow_err), word_t'(0));

        // ---------------- Drain with random gaps ----------------
        for (int i = 0; i < DEPTH; i++) begin
            gap = $urandom_range(0, 9);
            for (int g = 0; g < gap; g++) begin
                step();
`ifndef FRAME_FIFO_SHOWAHEAD_EN
                if (i > 0) begin
                    check($sformatf("drain_gap_valid_%0d", i), word_t'(rd_valid), word_t'(0));
                    check($sformatf("drain_gap_hold_%0d", i), rd_data, word_t'(i - 1));
                end
`endif
            end
            pop_check(word_t'(i), $sformatf("drain_%0d", i));
            check($sformatf("drain_usedw_%0d", i), word_t'(usedw), word_t'(DEPTH - 1 - i));
        end
        step();
`ifndef FRAME_FIFO_SHOWAHEAD_EN
        check("drain_valid_pulse", word_t'(rd_valid), word_t'(0));
`endif
        check("drain_empty", word_t'(rd_empty), word_t'(1));
        check("drain_full",  word_t'(wr_full),  word_t'(0));
        check("drain_burst", word_t'(burst_ok), word_t'(1));

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("unf_flag",  word_t'(underflow_err), word_t'(1));
        check("unf_usedw", word_t'(usedw),         word_t'(0));
`ifndef FRAME_FIFO_SHOWAHEAD_EN
        check("unf_no_valid", word_t'(rd_valid), word_t'(0));
        check("unf_hold",     rd_data,           word_t'(255));
`endif
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("unf_cleared", word_t'(underflow_err), word_t'(0));

        // ---------------- Wrap-around ----------------
        for (int i = 0; i < 200; i++) do_write(word_t'(1000 + i));
        check("wrap_usedw_200", word_t'(usedw), word_t'(200));
        for (int i = 0; i < 200; i++) pop_check(word_t'(1000 + i), $sformatf("wrap_a_%0d", i));
        check("wrap_usedw_0a", word_t'(usedw), word_t'(0));
        for (int i = 0; i < 100; i++) do_write(word_t'(2000 + i));
        check("wrap_usedw_100", word_t'(usedw), word_t'(100));
        for (int i = 0; i < 100; i++) pop_check(word_t'(2000 + i), $sformatf("wrap_b_%0d", i));
        check("wrap_usedw_0b", word_t'(usedw),    word_t'(0));
        check("wrap_empty",    word_t'(rd_empty), word_t'(1));

        // ---------------- Simultaneous read/write at full ----------------
        for (int i = 0; i < DEPTH; i++) do_write(word_t'(3000 + i));
        check("simf_full", word_t'(wr_full), word_t'(1));
`ifdef FRAME_FIFO_SHOWAHEAD_EN
        check("simf_head", rd_data, word_t'(3000));
`endif
        wr_en = 1'b1; wr_data = word_t'(16'h5555); rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("simf_usedw", word_t'(usedw),        word_t'(256));
        check("simf_ovf",   word_t'(overflow_err), word_t'(0));
        check("simf_full2", word_t'(wr_full),      word_t'(1));
`ifndef FRAME_FIFO_SHOWAHEAD_EN
        check("simf_valid", word_t'(rd_valid), word_t'(1));
        check("simf_data",  rd_data,           word_t'(3000));
`endif
        for (int i = 1; i < DEPTH; i++) pop_check(word_t'(3000 + i), $sformatf("simf_rd_%0d", i));
        pop_check(word_t'(16'h5555), "simf_last");
        check("simf_usedw_0", word_t'(usedw), word_t'(0));

        // ---------------- Simultaneous read/write at empty ----------------
        wr_en = 1'b1; wr_data = word_t'(8'h77); rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("sime_unf",   word_t'(underflow_err), word_t'(1));
        check("sime_usedw", word_t'(usedw),         word_t'(1));
`ifndef FRAME_FIFO_SHOWAHEAD_EN
        check("sime_no_valid", word_t'(rd_valid), word_t'(0));
`endif
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("sime_cleared", word_t'(underflow_err), word_t'(0));
        pop_check(word_t'(8'h77), "sime_rd");
        check("sime_usedw_0", word_t'(usedw), word_t'(0));

        // ---------------- Reset mid-operation ----------------
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("rmid_unf_set", word_t'(underflow_err), word_t'(1));
        for (int i = 0; i < 38; i++) do_write(word_t'(4000 + i));
        pop_check(word_t'(4000), "rmid_pop");
        check("rmid_usedw_37", word_t'(usedw), word_t'(37));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("rmid");
        step();
        check("rmid_still_empty", word_t'(rd_empty), word_t'(1));
        for (int i = 0; i < 5; i++) do_write(word_t'(5000 + i));
        check("rmid_usedw_5", word_t'(usedw), word_t'(5));
        for (int i = 0; i < 5; i++) pop_check(word_t'(5000 + i), $sformatf("rmid_rd_%0d", i));
        check("rmid_final_usedw", word_t'(usedw),    word_t'(0));
        check("rmid_final_empty", word_t'(rd_empty), word_t'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
